// File: rtl/vm_pkg.sv
// Shared types and default constants for the coffee vending machine controller.
// Holds the sequencer state encoding, the latched drink code, the credit and
// phase counter widths, and default prices and phase lengths.
package vm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WATER,
        ST_COFFEE,
        ST_CREAM,
        ST_SUGAR,
        ST_CHANGE
    } state_t;

    typedef enum logic [1:0] {
        DRINK_NONE,
        DRINK_BLACK,
        DRINK_CREAM,
        DRINK_CREAM_SUGAR
    } drink_t;

    localparam int MONEY_W = 5;
    localparam int PHASE_W = 8;

    typedef logic [MONEY_W-1:0] money_t;
    typedef logic [PHASE_W-1:0] phase_t;

    localparam money_t MONEY_MAX = '1;

    localparam int DEF_TICK_DIV          = 1000000;
    localparam int DEF_PRICE_BLACK       = 2;
    localparam int DEF_PRICE_CREAM       = 3;
    localparam int DEF_PRICE_CREAM_SUGAR = 4;
    localparam int DEF_T_WATER           = 200;
    localparam int DEF_T_COFFEE          = 100;
    localparam int DEF_T_CREAM           = 50;
    localparam int DEF_T_SUGAR           = 50;

endpackage

// File: rtl/vm_tick_gen.sv
// Tick prescaler: counts FPGA_CLK cycles 0..TICK_DIV-1 and flags the last
// count as a one-cycle tick enable.
// Ports:
//   FPGA_CLK   system clock
//   FPGA_RSTB  asynchronous active-low reset
//   clr        restart the count at 0 on the next cycle
//   tick       high while the count sits at TICK_DIV-1
module vm_tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic FPGA_CLK,
    input  logic FPGA_RSTB,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef logic [CNT_W-1:0] count_t;

    localparam count_t LAST = count_t'(TICK_DIV - 1);

    count_t count;

    // tick must not depend on clr: the top derives clr from transitions that
    // are themselves decided by tick.
    assign tick = (count == LAST);

    always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
        if (!FPGA_RSTB) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/coffee_dispense_sequencer.sv
// Coffee vending machine controller: keeps the coin credit, checks the price
// of the selected drink, deducts it and runs the valves through timed phases,
// then pays change one coin per tick on request.
// Ports:
//   FPGA_CLK, FPGA_RSTB          clock, asynchronous active-low reset
//   coin_pulse, change_req       one-cycle pulses: coin in, return credit
//   sel_black/cream/cream_sugar  one-cycle drink selection pulses
//   money                        current credit 0..31
//   water, coffee, cream, sugar  valve enables (level)
//   change_pulse                 one pulse per coin returned
//   coin_reject, err_funds, done one-cycle status pulses
//   busy                         high in every state except IDLE
module coffee_dispense_sequencer
    import vm_pkg::*;
#(
    parameter int TICK_DIV          = DEF_TICK_DIV,
    parameter int PRICE_BLACK       = DEF_PRICE_BLACK,
    parameter int PRICE_CREAM       = DEF_PRICE_CREAM,
    parameter int PRICE_CREAM_SUGAR = DEF_PRICE_CREAM_SUGAR,
    parameter int T_WATER           = DEF_T_WATER,
    parameter int T_COFFEE          = DEF_T_COFFEE,
    parameter int T_CREAM           = DEF_T_CREAM,
    parameter int T_SUGAR           = DEF_T_SUGAR
) (
    input  logic         FPGA_CLK,
    input  logic         FPGA_RSTB,
    input  logic         coin_pulse,
    input  logic         change_req,
    input  logic         sel_black,
    input  logic         sel_cream,
    input  logic         sel_cream_sugar,
    output logic [4:0]   money,
    output logic         water,
    output logic         coffee,
    output logic         cream,
    output logic         sugar,
    output logic         change_pulse,
    output logic         coin_reject,
    output logic         err_funds,
    output logic         busy,
    output logic         done
);

    localparam money_t P_BLACK       = money_t'(PRICE_BLACK);
    localparam money_t P_CREAM       = money_t'(PRICE_CREAM);
    localparam money_t P_CREAM_SUGAR = money_t'(PRICE_CREAM_SUGAR);
    localparam phase_t LAST_WATER    = phase_t'(T_WATER - 1);
    localparam phase_t LAST_COFFEE   = phase_t'(T_COFFEE - 1);
    localparam phase_t LAST_CREAM    = phase_t'(T_CREAM - 1);
    localparam phase_t LAST_SUGAR    = phase_t'(T_SUGAR - 1);

    state_t state, state_next;
    drink_t drink, drink_next, sel_drink;
    money_t money_next, price, coin_inc;
    phase_t phase_cnt, phase_next, phase_last;
    logic   tick, tick_clr, coin_ok, phase_done;
    logic   reject_next, err_next, change_next, done_next;

    vm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .FPGA_CLK  (FPGA_CLK),
        .FPGA_RSTB (FPGA_RSTB),
        .clr       (tick_clr),
        .tick      (tick)
    );

    // Coins are accepted everywhere except CHANGE, and never past 31 so the
    // credit cannot wrap.
    assign coin_ok  = coin_pulse && (money != MONEY_MAX) && (state != ST_CHANGE);
    assign coin_inc = {{(MONEY_W-1){1'b0}}, coin_ok};

    // Next-state, credit and pulse decisions for the registered outputs.
    always_comb begin
        state_next  = state;
        drink_next  = drink;
        money_next  = money + coin_inc;
        reject_next = coin_pulse && !coin_ok;
        err_next    = 1'b0;
        change_next = 1'b0;
        done_next   = 1'b0;
        sel_drink   = DRINK_NONE;
        price       = '0;
        phase_last  = '0;

        if (sel_black) begin
            sel_drink = DRINK_BLACK;
            price     = P_BLACK;
        end else if (sel_cream) begin
            sel_drink = DRINK_CREAM;
            price     = P_CREAM;
        end else if (sel_cream_sugar) begin
            sel_drink = DRINK_CREAM_SUGAR;
            price     = P_CREAM_SUGAR;
        end

        case (state)
            ST_WATER:  phase_last = LAST_WATER;
            ST_COFFEE: phase_last = LAST_COFFEE;
            ST_CREAM:  phase_last = LAST_CREAM;
            ST_SUGAR:  phase_last = LAST_SUGAR;
            default:   phase_last = '0;
        endcase
        phase_done = tick && (phase_cnt == phase_last);

        case (state)
            ST_IDLE: begin
                // A selection outranks change_req in the same cycle.
                if (sel_drink != DRINK_NONE) begin
                    if (money >= price) begin
                        money_next = money - price + coin_inc;
                        drink_next = sel_drink;
                        state_next = ST_WATER;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (change_req && (money != '0)) begin
                    state_next = ST_CHANGE;
                end
            end
            ST_WATER: begin
                if (phase_done) state_next = ST_COFFEE;
            end
            ST_COFFEE: begin
                if (phase_done) state_next = (drink == DRINK_BLACK) ? ST_IDLE : ST_CREAM;
            end
            ST_CREAM: begin
                if (phase_done) state_next = (drink == DRINK_CREAM_SUGAR) ? ST_SUGAR : ST_IDLE;
            end
            ST_SUGAR: begin
                if (phase_done) state_next = ST_IDLE;
            end
            ST_CHANGE: begin
                money_next = money;
                if (money == '0) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    change_next = 1'b1;
                    money_next  = money - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if ((state != ST_IDLE) && (state != ST_CHANGE) && (state_next == ST_IDLE)) begin
            done_next  = 1'b1;
            drink_next = DRINK_NONE;
        end

        // Every state entry restarts both the prescaler and the phase count,
        // so a phase of T ticks lasts exactly T*TICK_DIV cycles.
        tick_clr = (state_next != state);
        if (tick_clr) begin
            phase_next = '0;
        end else if (tick) begin
            phase_next = phase_cnt + 1'b1;
        end else begin
            phase_next = phase_cnt;
        end
    end

    // State, credit and registered outputs; reset drops valves and credit at once.
    always_ff @(posedge FPGA_CLK or negedge FPGA_RSTB) begin
        if (!FPGA_RSTB) begin
            state        <= ST_IDLE;
            drink        <= DRINK_NONE;
            phase_cnt    <= '0;
            money        <= '0;
            water        <= 1'b0;
            coffee       <= 1'b0;
            cream        <= 1'b0;
            sugar        <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            err_funds    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            drink        <= drink_next;
            phase_cnt    <= phase_next;
            money        <= money_next;
            water        <= (state_next == ST_WATER);
            coffee       <= (state_next == ST_COFFEE);
            cream        <= (state_next == ST_CREAM);
            sugar        <= (state_next == ST_SUGAR);
            change_pulse <= change_next;
            coin_reject  <= reject_next;
            err_funds    <= err_next;
            busy         <= (state_next != ST_IDLE);
            done         <= done_next;
        end
    end

endmodule
